sram_arbiter: RTL and testbench

Two-port arbiter that shares the single SRAM controller between the memory stage (port 0) and a second requester (port 1, instruction fetch or DMA). It latches one request, drives the SRAM controller command interface until that controller reports completion, then returns read data and a one-cycle completion to the winning port. Ports stall on their own ready signals exactly as the memory stage stalls on the SRAM controller's ready.

---
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM controller: latches one request, runs it to completion,
// then returns read data and a one-cycle ready to the winner. Define ARB_ROUND_ROBIN_EN for alternating tie grants.
module sram_arbiter #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_rd_en,
  input  logic          p0_wr_en,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [RW-1:0] p0_rdata,
  output logic          p0_ready,
  input  logic          p1_rd_en,
  input  logic          p1_wr_en,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [RW-1:0] p1_rdata,
  output logic          p1_ready,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [RW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic           grant_q;
  logic           busy_q;
  logic           mem_rd_en_q;
  logic           mem_wr_en_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic [RW-1:0]  p0_rdata_q;
  logic [RW-1:0]  p1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic           last_grant_q;
`endif

  logic           req0;
  logic           req1;
  logic           win;
  logic           win_wr;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_wdata;

  assign req0 = p0_rd_en | p0_wr_en;
  assign req1 = p1_rd_en | p1_wr_en;

  // Winner selection; a single requester always wins
  always_comb begin
    win = req1 & ~req0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      win = ~last_grant_q;
    end
`endif
  end

  // Both enables high counts as a write
  assign win_wr    = win ? p1_wr_en : p0_wr_en;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q      <= BUSY;
            grant_q      <= win;
            busy_q       <= 1'b1;
            mem_wr_en_q  <= win_wr;
            mem_rd_en_q  <= ~win_wr;
            mem_addr_q   <= win_addr;
            mem_wdata_q  <= win_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= win;
`endif
          end
        end
        BUSY: begin
          // Command stays frozen until the controller reports completion
          if (mem_ready) begin
            state_q     <= DONE;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            if (mem_rd_en_q) begin
              if (grant_q) begin
                p1_rdata_q <= mem_rdata;
              end else begin
                p0_rdata_q <= mem_rdata;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p0_ready  = ~req0 | ((state_q == DONE) & ~grant_q);
  assign p1_ready  = ~req1 | ((state_q == DONE) &  grant_q);
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized two-port traffic against a
// transaction-level model with an SRAM controller stub of variable latency.
module tb_sram_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 64;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_rd_en = 1'b0, p0_wr_en = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic [RW-1:0] p0_rdata;
  logic          p0_ready;
  logic          p1_rd_en = 1'b0, p1_wr_en = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic [RW-1:0] p1_rdata;
  logic          p1_ready;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester intent per port
  bit            rq_rd [2];
  bit            rq_wr [2];
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_wdata [2];

  // Transaction-level model: one access occupies cycles s (grant) .. s+lat+1 (completion)
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_s = 0;
  int            m_lat = 6;
  bit            m_port, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_last = 1'b1;
  logic [RW-1:0] exp_rdata [2];
  int            done_tot = 0;
  bit            grants [$];

  // Controller stub and stimulus knobs
  int            ctl_cnt = 0;
  int            lat_cfg = 6;
  bit            rand_lat = 1'b0, spur_en = 1'b0, hold_mode = 1'b0, fix_en = 1'b1;
  logic [RW-1:0] fix_rdata = '0;

  // Observed ready pulses while requesting
  int            rdy_cnt [2];
  int            rdy_cyc [2];

  task automatic drive_ports();
    p0_rd_en = rq_rd[0]; p0_wr_en = rq_wr[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wdata[0];
    p1_rd_en = rq_rd[1]; p1_wr_en = rq_wr[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wdata[1];
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_last = 1'b1; ctl_cnt = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic tick();
    bit busy_ph, done_ph, cmd, r0, r1, w;
    @(posedge clk); #1;
    cyc++;
    busy_ph = m_act && (cyc > m_s) && (cyc <= m_s + m_lat);
    done_ph = m_act && (cyc == m_s + m_lat + 1);
    chk("mem_rd_en", 64'(mem_rd_en), 64'(busy_ph && !m_wr));
    chk("mem_wr_en", 64'(mem_wr_en), 64'(busy_ph && m_wr));
    chk("busy", 64'(busy), 64'(busy_ph || done_ph));
    if (busy_ph) begin
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    chk("p0_rdata", p0_rdata, exp_rdata[0]);
    chk("p1_rdata", p1_rdata, exp_rdata[1]);
    // Controller completes after lat_cfg cycles of command; may also glitch ready while idle
    cmd = mem_rd_en | mem_wr_en;
    ctl_cnt = cmd ? ctl_cnt + 1 : 0;
    mem_ready = cmd ? (ctl_cnt == lat_cfg) : (spur_en && ($urandom_range(3) == 0));
    mem_rdata = fix_en ? fix_rdata : {$urandom, $urandom};
    drive_ports();
    #1;
    r0 = rq_rd[0] | rq_wr[0];
    r1 = rq_rd[1] | rq_wr[1];
    chk("p0_ready", 64'(p0_ready), 64'(!r0 || (done_ph && !m_port)));
    chk("p1_ready", 64'(p1_ready), 64'(!r1 || (done_ph && m_port)));
    if (r0 && p0_ready) begin rdy_cnt[0]++; rdy_cyc[0] = cyc; end
    if (r1 && p1_ready) begin rdy_cnt[1]++; rdy_cyc[1] = cyc; end
    if (busy_ph && (cyc == m_s + m_lat) && !m_wr) exp_rdata[m_port] = mem_rdata;
    if (done_ph) begin
      done_tot++;
      if (!hold_mode) begin rq_rd[m_port] = 1'b0; rq_wr[m_port] = 1'b0; end
    end
    if (!busy_ph && !done_ph && (r0 || r1)) begin
      if (r0 && r1) w = RR ? !m_last : 1'b0;
      else          w = r1;
      m_act = 1'b1; m_s = cyc; m_port = w; m_wr = rq_wr[w];
      m_addr = rq_addr[w]; m_wdata = rq_wdata[w];
      if (rand_lat) lat_cfg = $urandom_range(8, 1);
      m_lat = lat_cfg; m_last = w;
      grants.push_back(w);
    end
  endtask

  task automatic wait_dones(input int target);
    int guard = 0;
    while (done_tot < target && guard < 200) begin tick(); guard++; end
    chk("completion_reached", 64'(done_tot), 64'(target));
  endtask

  task automatic rand_ports();
    int k;
    for (int p = 0; p < 2; p++) begin
      if (!(rq_rd[p] || rq_wr[p])) begin
        if ($urandom_range(2) == 0) begin
          k = $urandom_range(2);
          rq_rd[p] = (k != 1); rq_wr[p] = (k != 0);
          rq_addr[p] = AW'($urandom); rq_wdata[p] = $urandom;
        end
      end else if ($urandom_range(49) == 0) begin
        rq_rd[p] = 1'b0; rq_wr[p] = 1'b0;
      end
    end
  endtask

  initial begin
    int n, rc;
    for (int p = 0; p < 2; p++) begin
      rq_rd[p] = 0; rq_wr[p] = 0; rq_addr[p] = '0; rq_wdata[p] = '0; rdy_cnt[p] = 0; rdy_cyc[p] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_p0_rdata", p0_rdata, 64'(0));
    chk("rst_p0_ready", 64'(p0_ready), 64'(1));
    @(negedge clk) rst = 1'b0;

    // Single read on port 0
    fix_rdata = 64'h4444_3333_2222_1111;
    rq_rd[0] = 1'b1; rq_addr[0] = 18'h00010;
    rc = rdy_cnt[0];
    wait_dones(done_tot + 1);
    chk("rd_ready_latency", 64'(rdy_cyc[0] - m_s), 64'(7));
    chk("rd_ready_pulses", 64'(rdy_cnt[0] - rc), 64'(1));
    chk("rd_data", p0_rdata, 64'h4444_3333_2222_1111);
    tick();

    // Both enables on port 0 is a write; rdata must not move
    fix_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    rq_rd[0] = 1'b1; rq_wr[0] = 1'b1; rq_addr[0] = 18'h00200; rq_wdata[0] = 32'h1234_5678;
    wait_dones(done_tot + 1);
    chk("both_en_is_write", 64'(m_wr), 64'(1));
    chk("both_en_rdata", p0_rdata, 64'h4444_3333_2222_1111);
    tick();

    // Single write on port 1 at top address
    rq_wr[1] = 1'b1; rq_addr[1] = 18'h3FFFF; rq_wdata[1] = 32'hDEAD_BEEF;
    rc = rdy_cnt[1];
    wait_dones(done_tot + 1);
    chk("wr_rdata_untouched", p1_rdata, 64'(0));
    chk("wr_ready_pulses", 64'(rdy_cnt[1] - rc), 64'(1));
    tick();

    // Simultaneous reads: port 0 first, then port 1
    fix_rdata = 64'h0A0A_0B0B_0C0C_0D0D;
    grants.delete();
    rq_rd[0] = 1'b1; rq_addr[0] = 18'h00001;
    rq_rd[1] = 1'b1; rq_addr[1] = 18'h00002;
    wait_dones(done_tot + 2);
    chk("tie_count", 64'(grants.size()), 64'(2));
    if (grants.size() >= 2) begin
      chk("tie_first", 64'(grants[0]), 64'(0));
      chk("tie_second", 64'(grants[1]), 64'(1));
    end
    tick();

    // Both held for four accesses
    grants.delete();
    hold_mode = 1'b1;
    rq_rd[0] = 1'b1; rq_rd[1] = 1'b1;
    wait_dones(done_tot + 4);
    rq_rd[0] = 1'b0; rq_rd[1] = 1'b0;
    hold_mode = 1'b0;
    tick();
    chk("hold_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("hold_grant", 64'(grants[i]), 64'(RR ? (i % 2) : 0));
    end

    // Port 1 withdraws during the third BUSY cycle
    fix_rdata = 64'hCAFE_F00D_0000_0001;
    rq_rd[1] = 1'b1; rq_addr[1] = 18'h01234;
    n = done_tot;
    tick(); tick(); tick();
    rq_rd[1] = 1'b0;
    wait_dones(n + 1);
    chk("withdraw_rdata", p1_rdata, 64'hCAFE_F00D_0000_0001);
    repeat (3) tick();

    // Reset in the middle of a read
    rq_rd[0] = 1'b1; rq_addr[0] = 18'h00123;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    chk("midrst_mem_wr_en", 64'(mem_wr_en), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_p0_rdata", p0_rdata, 64'(0));
    chk("midrst_p1_rdata", p1_rdata, 64'(0));
    rq_rd[0] = 1'b0; drive_ports(); mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    fix_rdata = 64'h0123_4567_89AB_CDEF;
    rq_rd[0] = 1'b1; rq_addr[0] = 18'h00040;
    wait_dones(done_tot + 1);
    chk("post_rst_read", p0_rdata, 64'h0123_4567_89AB_CDEF);
    tick();

    // Random traffic
    rand_lat = 1'b1; spur_en = 1'b1; fix_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rand_ports();
      tick();
    end
    for (int p = 0; p < 2; p++) begin rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
